// File: rtl/conv_pkg.sv
// Shared constants and helpers for the convolver multiplier array.
package conv_pkg;

    localparam int KERNEL_SIZE_DEF = 5;
    localparam int DATA_WIDTH_DEF  = 16;
    localparam int FRAC_BIT_DEF    = 8;

    // Widest element supported by sat_round; callers narrow the return value.
    localparam int MAX_W = 32;

    typedef logic signed [2*MAX_W-1:0] prod_t;
    typedef logic signed [2*MAX_W:0]   wide_t;

    // Round half toward +inf, shift down by fb, clamp to a dw-bit signed range.
    function automatic logic signed [MAX_W-1:0] sat_round(
        input prod_t prod,
        input int    dw,
        input int    fb
    );
        wide_t w_sum;
        wide_t w_hi;
        wide_t w_lo;
        w_sum = wide_t'(prod) + (wide_t'(1) <<< (fb - 1));
        w_sum = w_sum >>> fb;
        w_hi  = (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
        w_lo  = -(wide_t'(1) <<< (dw - 1));
        if (w_sum > w_hi) begin
            return w_hi[MAX_W-1:0];
        end else if (w_sum < w_lo) begin
            return w_lo[MAX_W-1:0];
        end else begin
            return w_sum[MAX_W-1:0];
        end
    endfunction

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/fxp_mult_lane.sv
// One signed fixed-point multiply lane: product register, then rounded/saturated result register.
module fxp_mult_lane
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FRAC_BIT   = FRAC_BIT_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] i_weight,
    input  logic signed [DATA_WIDTH-1:0] i_pixel,
    output logic signed [DATA_WIDTH-1:0] o_result
);

    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0]         w_prod_p0;
    logic signed [PW-1:0]         r_prod_p1;
    logic signed [DATA_WIDTH-1:0] r_res_p2;

    assign w_prod_p0 = PW'(i_weight) * PW'(i_pixel);

    // Stage 1: exact full-width product
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prod_p1 <= '0;
        end else begin
            r_prod_p1 <= w_prod_p0;
        end
    end

    // Stage 2: rescale back to the element format
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_p2 <= '0;
        end else begin
            r_res_p2 <= DATA_WIDTH'(sat_round(prod_t'(r_prod_p1), DATA_WIDTH, FRAC_BIT));
        end
    end

    assign o_result = r_res_p2;

endmodule

// File: rtl/conv_mult_array.sv
// Element-wise multiplier array over a flattened kernel window; lanes are independent.
module conv_mult_array
    import conv_pkg::*;
#(
    parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int FRAC_BIT    = FRAC_BIT_DEF
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        in_valid,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] weights,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] pixel_data,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] result,
    output logic                                        out_valid
);

    localparam int N = KERNEL_SIZE * KERNEL_SIZE;

    logic r_vld_p1;
    logic r_vld_p2;

    for (genvar i = 0; i < N; i++) begin : g_lane
        fxp_mult_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .FRAC_BIT   (FRAC_BIT)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .i_weight (weights[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
            .i_pixel  (pixel_data[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
            .o_result (result[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH])
        );
    end

    // Valid travels alongside the two lane stages
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else begin
            r_vld_p1 <= in_valid;
            r_vld_p2 <= r_vld_p1;
        end
    end

    assign out_valid = r_vld_p2;

endmodule

// File: tb/tb_conv_mult_array.sv
// Directed and model-checked bench for conv_mult_array (5x5 lanes, Q8.8).
module tb_conv_mult_array;

    localparam int N  = 25;
    localparam int DW = 16;
    localparam int VW = N * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [VW-1:0] weights = '0;
    logic [VW-1:0] pixel_data = '0;
    logic [VW-1:0] result;
    logic          out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // scoreboard pipe: what each stage should hold
    logic          sb_vld1 = 1'b0;
    logic          sb_vld2 = 1'b0;
    logic [VW-1:0] sb_res1 = '0;
    logic [VW-1:0] sb_res2 = '0;

    conv_mult_array #(
        .KERNEL_SIZE (5),
        .DATA_WIDTH  (DW),
        .FRAC_BIT    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .weights    (weights),
        .pixel_data (pixel_data),
        .result     (result),
        .out_valid  (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_lane(input logic [DW-1:0] w, input logic [DW-1:0] p);
        longint pr;
        pr = longint'($signed(w)) * longint'($signed(p));
        pr = (pr + 128) >>> 8;
        if (pr > 32767) pr = 32767;
        if (pr < -32768) pr = -32768;
        return pr[DW-1:0];
    endfunction

    function automatic logic [VW-1:0] ref_vec(input logic [VW-1:0] w, input logic [VW-1:0] p);
        logic [VW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[i*DW +: DW] = ref_lane(w[i*DW +: DW], p[i*DW +: DW]);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one clock with scoreboard tracking, then compare outputs
    task automatic step(input string tag);
        logic [VW-1:0] m;
        m = ref_vec(weights, pixel_data);
        tick();
        sb_vld2 = sb_vld1;
        sb_res2 = sb_res1;
        sb_vld1 = in_valid;
        sb_res1 = m;
        chk({tag, "_vld"}, VW'(out_valid), VW'(sb_vld2));
        if (sb_vld2) chk({tag, "_res"}, result, sb_res2);
    endtask

    task automatic set_all(input logic [DW-1:0] w, input logic [DW-1:0] p);
        for (int i = 0; i < N; i++) begin
            weights[i*DW +: DW]    = w;
            pixel_data[i*DW +: DW] = p;
        end
    endtask

    logic [DW-1:0] dw_tab [8] = '{16'hFF00, 16'hFF00, 16'h0001, 16'hFFFF, 16'h0001, 16'h7F00, 16'h8000, 16'h8000};
    logic [DW-1:0] dp_tab [8] = '{16'h0280, 16'hFF00, 16'h0080, 16'h0080, 16'h007F, 16'h0200, 16'h8000, 16'h0200};
    logic [DW-1:0] de_tab [8] = '{16'hFD80, 16'h0100, 16'h0001, 16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF, 16'h8000};

    initial begin
        logic [VW-1:0] exp_all;

        // reset state
        tick();
        tick();
        chk("rst_vld", VW'(out_valid), '0);
        chk("rst_res", result, '0);
        rst = 1'b0;
        tick();
        chk("idle_vld", VW'(out_valid), '0);

        // basic: 1.5 * 2.0 on every lane
        set_all(16'h0180, 16'h0200);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("basic_vld_k", VW'(out_valid), '0);
        tick();
        for (int i = 0; i < N; i++) exp_all[i*DW +: DW] = 16'h0300;
        chk("basic_vld_k1", VW'(out_valid), VW'(1'b1));
        chk("basic_res", result, exp_all);
        tick();
        chk("basic_vld_off", VW'(out_valid), '0);

        // sign, rounding and saturation corners, one per lane
        set_all(16'h0000, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            weights[i*DW +: DW]    = dw_tab[i];
            pixel_data[i*DW +: DW] = dp_tab[i];
        end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("corner_vld", VW'(out_valid), VW'(1'b1));
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("corner_l%0d", i), VW'(result[i*DW +: DW]), VW'(de_tab[i]));
        end
        chk("corner_zero_l8", VW'(result[8*DW +: DW]), '0);
        tick();
        chk("corner_vld_off", VW'(out_valid), '0);
        tick();
        sb_vld1 = 1'b0;
        sb_vld2 = 1'b0;

        // streaming: 10 back-to-back windows, lane weight (i+1)*1.0
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < N; i++) begin
                weights[i*DW +: DW]    = DW'((i + 1) * 16'h0100);
                pixel_data[i*DW +: DW] = DW'(c * 16'h0031 + i * 7 - 16'h0080);
            end
            in_valid = 1'b1;
            step($sformatf("stream%0d", c));
        end
        in_valid = 1'b0;
        step("stream_drain0");
        step("stream_drain1");
        step("stream_drain2");

        // random windows, in_valid mostly high
        for (int c = 0; c < 1000; c++) begin
            for (int i = 0; i < N; i++) begin
                weights[i*DW +: DW]    = DW'($urandom);
                pixel_data[i*DW +: DW] = DW'($urandom);
            end
            in_valid = ($urandom_range(0, 7) != 0);
            step("rand");
        end

        // reset mid-stream
        in_valid = 1'b1;
        set_all(16'h0100, 16'h0123);
        step("pre_rst0");
        step("pre_rst1");
        step("pre_rst2");
        #2;
        rst = 1'b1;
        #1;
        chk("arst_vld", VW'(out_valid), '0);
        chk("arst_res", result, '0);
        tick();
        chk("arst_hold_vld", VW'(out_valid), '0);
        chk("arst_hold_res", result, '0);
        in_valid = 1'b0;
        rst = 1'b0;
        sb_vld1 = 1'b0;
        sb_vld2 = 1'b0;
        step("post_rst0");
        step("post_rst1");
        set_all(16'hFE80, 16'h0300);
        in_valid = 1'b1;
        step("post_rst_in");
        in_valid = 1'b0;
        step("post_rst_k1");
        for (int i = 0; i < N; i++) exp_all[i*DW +: DW] = 16'hFB80;
        chk("post_rst_res", result, exp_all);
        step("post_rst_k2");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1);
    end

endmodule
